matmul_operand_sequencer: RTL and testbench
===========================================

Name: matmul_operand_sequencer

Overview:
- Upstream stage of the FP MAC matrix-multiply datapath. On a start handshake it reads the dimension headers from the input and weight SRAMs, then issues one input/weight read-address pair per cycle for every (i,j,k) of C = A x B.
- Emits a cycle-aligned operand strobe with accumulate-clear, accumulate-last and result-address tags so the MAC/write-back stage consumes SRAM read data directly.
- Owns only read addressing and sequencing; it does no arithmetic on data words.

Parameters:
- ADDR_W, 16, SRAM address width; equals `SRAM_ADDR_WIDTH.
- DATA_W, 32, SRAM data width; equals `SRAM_DATA_WIDTH. Each dimension field is DATA_W/2 bits wide.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start_valid  in  1  request to run one matrix multiply
- seq_ready  out  1  high when idle and able to accept start_valid
- input_read_address  out  ADDR_W  input SRAM read address
- input_read_data  in  DATA_W  input SRAM read data, valid 1 cycle after its address
- weight_read_address  out  ADDR_W  weight SRAM read address
- weight_read_data  in  DATA_W  weight SRAM read data, valid 1 cycle after its address
- op_valid  out  1  SRAM read data this cycle is an operand pair
- op_first  out  1  first k of a dot product; accumulator loads 0
- op_last  out  1  last k of a dot product; result to be written
- op_res_addr  out  ADDR_W  result SRAM address for the current dot product
- res_rows  out  DATA_W/2  M, latched from the header
- res_cols  out  DATA_W/2  N, latched from the header
- done  out  1  one-cycle pulse at the end of a job
- err  out  1  dimension mismatch; valid while done is high

Behaviour:
- Reset and async clock domain:
  - Reset is asynchronous and active-low on reset_n, with a single clock clk.
  - Reset values: state IDLE; all addresses 0; op_* 0; done 0; err 0; res_rows/res_cols 0; seq_ready 1.
- Memory layout:
  - Input word0 holds M in [DATA_W-1:DATA_W/2] and K in [DATA_W/2-1:0]. A is stored row-major from address 1.
  - Weight word0 holds K_w in the high half and N in the low half. B is stored column-major from address 1, so element (k,j) is at 1+j*K+k.
  - The result address for (i,j) is 1+i*N+j; address 0 is reserved for the result header written downstream.
- Handshake:
  - seq_ready = (state==IDLE).
  - start_valid is sampled only in IDLE and ignored in every other state.
- States:
  - IDLE: seq_ready=1. start_valid -> HDR with both read addresses set to 0.
  - HDR: address 0 is presented. -> CAP.
  - CAP: header data is present. Latch M, K, K_w, N and drive res_rows/res_cols.
    - If K != K_w: err is set; go to DONE.
    - Else if M, N or K is 0: go to DONE with err=0 and no operands.
    - Else: go to STREAM with i=j=k=0, input address 1, weight address 1, res address 1.
  - STREAM: one address pair per cycle.
    - k increments each cycle.
    - At k=K-1: k<-0 and j++. The weight address keeps incrementing and the input address returns to rowbase.
    - At j=N-1 and k=K-1: j<-0, i++, rowbase+=K, and the weight address resets to 1.
    - The result address increments at every k=K-1.
    - At i=M-1, j=N-1, k=K-1 -> DRAIN.
  - DRAIN: one cycle so the final operand strobe retires. -> DONE.
  - DONE: done=1 for exactly one cycle. -> IDLE.
- Operand pipeline:
  - The tags {valid, first=(k==0), last=(k==K-1), res_addr} are registered in the cycle the address is issued, so op_* rises exactly one cycle after the matching address.
  - This gives an address->op_valid latency of 1 and a header-start->first op_valid latency of 4 cycles (start accepted cycle 0, HDR 1, CAP 2, first address 3, op_valid 4).
  - op_valid is high for exactly M*N*K consecutive cycles; there are no bubbles and no backpressure.
  - op_first and op_last are both high when K=1.
- Arithmetic:
  - All counters and addresses are unsigned.
  - Addresses are computed by increment and add only, with no multipliers.
  - Wrap-around beyond 2^ADDR_W is modulo; the caller guarantees M*K+1, N*K+1 and M*N+1 are at most 2^ADDR_W.
- Other rules:
  - err is cleared at the next accepted start.
  - res_rows/res_cols hold until the next CAP.
  - A reset asserted mid-job aborts immediately to IDLE with no done pulse; the next job restarts cleanly.

Decomposition:
- Shared package (matmul_pkg): the state enum, the dimension-field slice constants (DIM_W = DATA_W/2, HI/LO field positions), and the header address constant HDR_ADDR = 0.
- One sub-module: matmul_idx_counter, a nested i/j/k counter with wrap flags and a terminal-count output. It is instanced once and drives address increment and reset enables.

Test Plan:
- 2x3 times 3x2 (input hdr 0x0002_0003, weight hdr 0x0003_0002): start -> 12 op_valid cycles.
  - Input address sequence 1,2,3,1,2,3,4,5,6,4,5,6.
  - Weight address sequence 1..6,1..6.
  - op_first at k=0 and op_last at k=2; op_res_addr 1,1,1,2,2,2,3,3,3,4,4,4.
  - done exactly 1 cycle after DRAIN.
- K=1 case (hdrs 0x0003_0001 and 0x0001_0002): 6 op_valid cycles, each with op_first=op_last=1; res_addr 1..6.
- Mismatch (input K=4, weight K_w=3): no op_valid, done pulse at cycle 3 after start with err=1; the next good job clears err.
- Zero dimension (M=0): no op_valid, done with err=0; res_rows=0.
- start_valid held high throughout a job and re-pulsed mid-STREAM: ignored; exactly one done per job and a second job starts only from IDLE.
- reset_n dropped mid-STREAM: all outputs return to reset values asynchronously with no done pulse; a subsequent 2x3x2 job matches scenario 1 exactly.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared definitions for the matrix-multiply operand sequencer: default SRAM
// geometry, header field positions and the sequencer state encoding.
package matmul_pkg;

  localparam int SRAM_ADDR_WIDTH = 16;
  localparam int SRAM_DATA_WIDTH = 32;

  localparam int DIM_W  = SRAM_DATA_WIDTH / 2;
  localparam int HI_MSB = SRAM_DATA_WIDTH - 1;
  localparam int HI_LSB = DIM_W;
  localparam int LO_MSB = DIM_W - 1;
  localparam int LO_LSB = 0;

  localparam logic [SRAM_ADDR_WIDTH-1:0] HDR_ADDR = '0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_CAP,
    S_STREAM,
    S_DRAIN,
    S_DONE
  } state_e;

endpackage

// File: rtl/matmul_operand_sequencer_if.sv
// Start handshake, SRAM read ports and operand-tag outputs of the sequencer.
// The master modport is the sequencer itself; slave is its environment.
interface matmul_operand_sequencer_if
  import matmul_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_WIDTH,
  parameter int DATA_W = SRAM_DATA_WIDTH
);
  localparam int DW = DATA_W / 2;

  logic              start_valid;
  logic              seq_ready;
  logic [ADDR_W-1:0] input_read_address;
  logic [DATA_W-1:0] input_read_data;
  logic [ADDR_W-1:0] weight_read_address;
  logic [DATA_W-1:0] weight_read_data;
  logic              op_valid;
  logic              op_first;
  logic              op_last;
  logic [ADDR_W-1:0] op_res_addr;
  logic [DW-1:0]     res_rows;
  logic [DW-1:0]     res_cols;
  logic              done;
  logic              err;

  modport master (
    input  start_valid, input_read_data, weight_read_data,
    output seq_ready, input_read_address, weight_read_address,
    output op_valid, op_first, op_last, op_res_addr,
    output res_rows, res_cols, done, err
  );

  modport slave (
    output start_valid, input_read_data, weight_read_data,
    input  seq_ready, input_read_address, weight_read_address,
    input  op_valid, op_first, op_last, op_res_addr,
    input  res_rows, res_cols, done, err
  );

endinterface

// File: rtl/matmul_idx_counter.sv
// Nested i/j/k loop counter for the operand stream; reports where k and j wrap
// and when the final (M-1, N-1, K-1) index is being issued.
module matmul_idx_counter #(
  parameter int DIM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             en_i,
  input  logic [DIM_W-1:0] m_i,
  input  logic [DIM_W-1:0] n_i,
  input  logic [DIM_W-1:0] k_i,
  output logic             k_first_o,
  output logic             k_last_o,
  output logic             j_last_o,
  output logic             tc_o
);

  localparam logic [DIM_W-1:0] ONE = DIM_W'(1);

  logic [DIM_W-1:0] i_q, j_q, k_q;

  assign k_first_o = (k_q == '0);
  assign k_last_o  = (k_q == k_i - ONE);
  assign j_last_o  = k_last_o && (j_q == n_i - ONE);
  assign tc_o      = j_last_o && (i_q == m_i - ONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (clear_i) begin
      i_q <= '0;
      j_q <= '0;
      k_q <= '0;
    end else if (en_i) begin
      if (k_last_o) begin
        k_q <= '0;
        if (j_last_o) begin
          j_q <= '0;
          i_q <= i_q + ONE;
        end else begin
          j_q <= j_q + ONE;
        end
      end else begin
        k_q <= k_q + ONE;
      end
    end
  end

endmodule

// File: rtl/matmul_operand_sequencer.sv
// Reads the A/B dimension headers, then issues one input/weight read-address
// pair per cycle for every (i,j,k) of C = A x B with cycle-aligned operand tags.
module matmul_operand_sequencer
  import matmul_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_WIDTH,
  parameter int DATA_W = SRAM_DATA_WIDTH
) (
  input logic                        clk,
  input logic                        reset_n,
  matmul_operand_sequencer_if.master bus
);

  localparam int DW = DATA_W / 2;
  localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);

  state_e            state_q;
  logic [ADDR_W-1:0] in_addr_q, w_addr_q, res_addr_q, rowbase_q;
  logic [DW-1:0]     m_q, n_q, k_q;
  logic              op_valid_q, op_first_q, op_last_q;
  logic [ADDR_W-1:0] op_res_addr_q;
  logic              done_q, err_q;

  logic [DW-1:0]     hdr_m, hdr_k, hdr_kw, hdr_n;
  logic [ADDR_W-1:0] k_step;
  logic              streaming, k_first, k_last, j_last, tc;

  assign hdr_m     = bus.input_read_data[DATA_W-1:DW];
  assign hdr_k     = bus.input_read_data[DW-1:0];
  assign hdr_kw    = bus.weight_read_data[DATA_W-1:DW];
  assign hdr_n     = bus.weight_read_data[DW-1:0];
  assign k_step    = ADDR_W'(k_q);
  assign streaming = (state_q == S_STREAM);

  matmul_idx_counter #(.DIM_W(DW)) u_idx (
    .clk       (clk),
    .rst_n     (reset_n),
    .clear_i   (state_q == S_CAP),
    .en_i      (streaming),
    .m_i       (m_q),
    .n_i       (n_q),
    .k_i       (k_q),
    .k_first_o (k_first),
    .k_last_o  (k_last),
    .j_last_o  (j_last),
    .tc_o      (tc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= S_IDLE;
      in_addr_q     <= '0;
      w_addr_q      <= '0;
      res_addr_q    <= '0;
      rowbase_q     <= '0;
      m_q           <= '0;
      n_q           <= '0;
      k_q           <= '0;
      op_valid_q    <= 1'b0;
      op_first_q    <= 1'b0;
      op_last_q     <= 1'b0;
      op_res_addr_q <= '0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults first; a later assignment in the case wins.
      done_q     <= 1'b0;
      // Tags describe the address issued this cycle, so they land with its data.
      op_valid_q <= streaming;
      op_first_q <= streaming && k_first;
      op_last_q  <= streaming && k_last;
      if (streaming) op_res_addr_q <= res_addr_q;

      case (state_q)
        S_IDLE: begin
          if (bus.start_valid) begin
            state_q   <= S_HDR;
            in_addr_q <= HDR_ADDR;
            w_addr_q  <= HDR_ADDR;
            err_q     <= 1'b0;
          end
        end
        S_HDR: state_q <= S_CAP;
        S_CAP: begin
          m_q <= hdr_m;
          k_q <= hdr_k;
          n_q <= hdr_n;
          if (hdr_k != hdr_kw) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else if (hdr_m == '0 || hdr_n == '0 || hdr_k == '0) begin
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            state_q    <= S_STREAM;
            in_addr_q  <= FIRST_ADDR;
            w_addr_q   <= FIRST_ADDR;
            res_addr_q <= FIRST_ADDR;
            rowbase_q  <= FIRST_ADDR;
          end
        end
        S_STREAM: begin
          if (tc) begin
            state_q <= S_DRAIN;
          end else if (j_last) begin
            rowbase_q  <= rowbase_q + k_step;
            in_addr_q  <= rowbase_q + k_step;
            w_addr_q   <= FIRST_ADDR;
            res_addr_q <= res_addr_q + FIRST_ADDR;
          end else if (k_last) begin
            in_addr_q  <= rowbase_q;
            w_addr_q   <= w_addr_q + FIRST_ADDR;
            res_addr_q <= res_addr_q + FIRST_ADDR;
          end else begin
            in_addr_q <= in_addr_q + FIRST_ADDR;
            w_addr_q  <= w_addr_q + FIRST_ADDR;
          end
        end
        S_DRAIN: begin
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.seq_ready           = (state_q == S_IDLE);
  assign bus.input_read_address  = in_addr_q;
  assign bus.weight_read_address = w_addr_q;
  assign bus.op_valid            = op_valid_q;
  assign bus.op_first            = op_first_q;
  assign bus.op_last             = op_last_q;
  assign bus.op_res_addr         = op_res_addr_q;
  assign bus.res_rows            = m_q;
  assign bus.res_cols            = n_q;
  assign bus.done                = done_q;
  assign bus.err                 = err_q;

endmodule

// File: tb/tb_matmul_operand_sequencer.sv
// Self-checking bench: an (i,j,k) loop model of the operand stream is compared
// against the DUT every cycle, with directed, randomized and reset-abort jobs.
module tb_matmul_operand_sequencer;

  localparam int AW = 16;
  localparam int DW = 32;

  typedef struct packed {
    logic [AW-1:0] in_a;
    logic [AW-1:0] w_a;
    logic [AW-1:0] res;
    logic          first;
    logic          last;
  } op_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  matmul_operand_sequencer_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  matmul_operand_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  // SRAM models: header at address 0, a recognisable pattern elsewhere.
  logic [DW-1:0] in_hdr = '0;
  logic [DW-1:0] w_hdr  = '0;
  always @(posedge clk) begin
    bus.input_read_data  <= (bus.input_read_address == '0) ? in_hdr : {16'hA000, bus.input_read_address};
    bus.weight_read_data <= (bus.weight_read_address == '0) ? w_hdr : {16'hB000, bus.weight_read_address};
  end

  int  compared   = 0;
  int  mismatched = 0;
  int  done_cnt   = 0;
  bit  in_stream  = 0;
  op_t exp_q[$];
  op_t log_q[$];
  logic [AW-1:0] prev_in = '0;
  logic [AW-1:0] prev_w  = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Expected stream straight from C[i][j] = sum_k A[i][k] * B[k][j] addressing.
  function automatic void build_model(input int m, input int k, input int kw, input int n);
    op_t e;
    if (k != kw) return;
    for (int i = 0; i < m; i++)
      for (int j = 0; j < n; j++)
        for (int kk = 0; kk < k; kk++) begin
          e.in_a  = AW'(1 + i * k + kk);
          e.w_a   = AW'(1 + j * k + kk);
          e.res   = AW'(1 + i * n + j);
          e.first = (kk == 0);
          e.last  = (kk == k - 1);
          exp_q.push_back(e);
        end
  endfunction

  // Compare process: every op_valid cycle pairs with the address of the cycle before.
  always @(negedge clk) begin
    op_t got;
    op_t e;
    if (reset_n) begin
      if (bus.op_valid) begin
        got.in_a  = prev_in;
        got.w_a   = prev_w;
        got.res   = bus.op_res_addr;
        got.first = bus.op_first;
        got.last  = bus.op_last;
        log_q.push_back(got);
        if (exp_q.size() == 0) begin
          check("unexpected op_valid", 64'(1), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("operand {in,w,res,first,last}", 64'(got), 64'(e));
        end
        in_stream = (exp_q.size() != 0);
      end else if (in_stream) begin
        check("op_valid bubble", 64'(0), 64'(1));
        in_stream = 0;
      end
      if (bus.done) done_cnt++;
      prev_in = bus.input_read_address;
      prev_w  = bus.weight_read_address;
    end
  end

  // mode 0: single-cycle start; 1: start held through the job; 2: re-pulse mid-stream.
  task automatic run_job(input int m, input int k, input int kw, input int n, input int mode);
    int exp_done;
    int cyc;
    bit seen;
    bit mism;
    mism     = (k != kw);
    exp_done = (mism || m == 0 || n == 0 || k == 0) ? 3 : 4 + m * n * k;
    in_hdr   = {m[15:0], k[15:0]};
    w_hdr    = {kw[15:0], n[15:0]};
    build_model(m, k, kw, n);
    log_q.delete();
    done_cnt = 0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    cyc  = 0;
    seen = 0;
    while (!seen && cyc < exp_done + 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check("busy after accept {seq_ready,err}", 64'({bus.seq_ready, bus.err}), 64'(0));
      if (mode != 1 && cyc == 1) bus.start_valid = 1'b0;
      if (mode == 2 && cyc == 6) bus.start_valid = 1'b1;
      if (mode == 2 && cyc == 7) bus.start_valid = 1'b0;
      if (bus.done) begin
        seen = 1;
        check("done cycle", 64'(cyc), 64'(exp_done));
        check("err at done", 64'(bus.err), 64'(mism));
        check("res {rows,cols}", 64'({bus.res_rows, bus.res_cols}), 64'({m[15:0], n[15:0]}));
      end
    end
    if (!seen) check("done timeout", 64'(0), 64'(1));
    bus.start_valid = 1'b0;
    @(negedge clk);
    check("post-job {done,seq_ready,one_done,model_drained}",
          64'({bus.done, bus.seq_ready, done_cnt == 1, exp_q.size() == 0}), 64'(4'b0111));
    exp_q.delete();
    in_stream = 0;
  endtask

  task automatic pin_2x3x2();
    int p_in[12]  = '{1, 2, 3, 1, 2, 3, 4, 5, 6, 4, 5, 6};
    int p_w[12]   = '{1, 2, 3, 4, 5, 6, 1, 2, 3, 4, 5, 6};
    int p_res[12] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4};
    int p_fst[12] = '{1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0};
    int p_lst[12] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    op_t e;
    check("2x3x2 op count", 64'(log_q.size()), 64'(12));
    for (int x = 0; x < 12 && x < log_q.size(); x++) begin
      e = '{AW'(p_in[x]), AW'(p_w[x]), AW'(p_res[x]), p_fst[x] != 0, p_lst[x] != 0};
      check($sformatf("2x3x2 literal op %0d", x), 64'(log_q[x]), 64'(e));
    end
  endtask

  task automatic pin_k1();
    int p_in[6] = '{1, 1, 2, 2, 3, 3};
    int p_w[6]  = '{1, 2, 1, 2, 1, 2};
    op_t e;
    check("K=1 op count", 64'(log_q.size()), 64'(6));
    for (int x = 0; x < 6 && x < log_q.size(); x++) begin
      e = '{AW'(p_in[x]), AW'(p_w[x]), AW'(x + 1), 1'b1, 1'b1};
      check($sformatf("K=1 literal op %0d", x), 64'(log_q[x]), 64'(e));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " addresses"},
          64'({bus.input_read_address, bus.weight_read_address, bus.op_res_addr}), 64'(0));
    check({tag, " flags/dims"},
          64'({bus.seq_ready, bus.op_valid, bus.op_first, bus.op_last, bus.done, bus.err,
               bus.res_rows, bus.res_cols}),
          64'({6'b100000, 32'h0}));
  endtask

  initial begin
    int m, k, kw, n;
    bus.start_valid = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    @(negedge clk);

    run_job(2, 3, 3, 2, 0);
    pin_2x3x2();
    run_job(3, 1, 1, 2, 0);
    pin_k1();
    run_job(2, 4, 3, 2, 0);
    run_job(2, 3, 3, 2, 0);
    run_job(0, 3, 3, 2, 0);
    run_job(2, 3, 3, 2, 1);
    run_job(3, 3, 3, 3, 2);
    run_job(5, 7, 7, 6, 0);

    // Abort a job mid-stream with an asynchronous reset.
    in_hdr = {16'd2, 16'd3};
    w_hdr  = {16'd3, 16'd2};
    build_model(2, 3, 3, 2);
    done_cnt = 0;
    @(negedge clk);
    bus.start_valid = 1'b1;
    @(negedge clk);
    bus.start_valid = 1'b0;
    repeat (5) @(negedge clk);
    check("op_valid before abort", 64'(bus.op_valid), 64'(1));
    #2 reset_n = 1'b0;
    exp_q.delete();
    in_stream = 0;
    #1 check_reset_outputs("async abort");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("no done on abort", 64'(done_cnt), 64'(0));
    run_job(2, 3, 3, 2, 0);
    pin_2x3x2();

    for (int r = 0; r < 24; r++) begin
      m  = $urandom_range(0, 4);
      k  = $urandom_range(0, 4);
      n  = $urandom_range(0, 4);
      kw = ($urandom_range(0, 5) == 0) ? k + 1 : k;
      run_job(m, k, kw, n, int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
